// File: rtl/motoro3_phase_mon_pkg.sv
// Shared types and helpers for the motoro3 gate-drive phase monitor.
package motoro3_phase_mon_pkg;

  // Output code meaning "no step decoded / not locked".
  localparam logic [2:0] STEP_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2
  } m3State_t;

  // The on-vector is ordered {aH, aL, bH, bL, cH, cL}, with 1 = device conducting.
  // Returns the commutation step 0..5 that this vector represents, or STEP_NONE.
  function automatic logic [2:0] decodeStep(input logic [5:0] onVec);
    logic [2:0] s;
    case (onVec)
      6'b100100: s = 3'd0;  // A high, B low
      6'b100001: s = 3'd1;  // A high, C low
      6'b001001: s = 3'd2;  // B high, C low
      6'b011000: s = 3'd3;  // B high, A low
      6'b010010: s = 3'd4;  // C high, A low
      6'b000110: s = 3'd5;  // C high, B low
      default:   s = STEP_NONE;
    endcase
    return s;
  endfunction

  // (newS - oldS) mod 6 for steps in 0..5.
  function automatic logic [2:0] stepDelta(input logic [2:0] newS, input logic [2:0] oldS);
    logic [3:0] t;
    t = {1'b0, newS} + 4'd6 - {1'b0, oldS};
    if (t >= 4'd6) t = t - 4'd6;
    return t[2:0];
  endfunction

endpackage

// File: rtl/motoro3_dead_chk.sv
// Per-phase checker: reports shoot-through and too-short dead time between
// one device of a phase turning off and its complement turning on.
module motoro3_dead_chk #(
  parameter int DEAD_MIN = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic hOn,
  input  logic lOn,
  output logic deadViol,
  output logic shootViol
);

  localparam int CW = $clog2(DEAD_MIN + 1);
  localparam logic [CW-1:0] SAT = CW'(DEAD_MIN);

  logic hPrev, lPrev;
  logic offWasH;            // which device of this phase turned off last
  logic [CW-1:0] offCnt;    // cycles both-off since that turn-off, saturating
  logic hFall, lFall, hRise, lRise;

  assign hFall = hPrev & ~hOn;
  assign lFall = lPrev & ~lOn;
  assign hRise = ~hPrev & hOn;
  assign lRise = ~lPrev & lOn;

  assign shootViol = hOn & lOn;
  // A simultaneous off/on swap is a zero-length gap and always a violation.
  assign deadViol = (lRise & (hFall | (offWasH & (offCnt < SAT)))) |
                    (hRise & (lFall | (~offWasH & (offCnt < SAT))));

  // Track previous levels and time since the most recent turn-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      hPrev   <= 1'b0;
      lPrev   <= 1'b0;
      offWasH <= 1'b0;
      offCnt  <= SAT;
    end else begin
      hPrev <= hOn;
      lPrev <= lOn;
      if (hFall | lFall) begin
        offCnt  <= CW'(1);
        offWasH <= hFall;
      end else if (offCnt < SAT) begin
        offCnt <= offCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motoro3_phase_mon.sv
// Monitor for the six motoro3 gate-drive lines: decodes commutation step,
// direction and step period, and raises sticky protection faults.
module motoro3_phase_mon
  import motoro3_phase_mon_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int DEAD_MIN  = 10,
  parameter int STALL_CYC = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aHP,
  input  logic             aLN,
  input  logic             bHP,
  input  logic             bLN,
  input  logic             cHP,
  input  logic             cLN,
  input  logic             m3faultClr,
  output logic [2:0]       m3step,
  output logic             m3running,
  output logic             m3dirRev,
  output logic             m3dirChg,
  output logic [CNT_W-1:0] m3period,
  output logic             m3periodVld,
  output logic             m3stalled,
  output logic             m3shootFlt,
  output logic             m3deadFlt,
  output logic             m3seqErr
);

  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYC);

  logic [5:0] onReg;
  logic       clrReg;
  logic [2:0] deadViol, shootViol;

  m3State_t         stateReg, stateNext;
  logic [2:0]       stepReg, stepNext, lastStepReg, lastStepNext;
  logic             dirRevReg, dirRevNext, dirChgReg, dirChgNext;
  logic [CNT_W-1:0] periodReg, periodNext, cntReg, cntNext, cntInc;
  logic             periodVldReg, periodVldNext, stalledReg, stalledNext;
  logic             shootFltReg, deadFltReg, seqErrReg, seqEvt;

  logic [2:0] newStep, delta;
  logic       stepValid, stepChg, badPat, stallHit;

  // Register the raw drive lines once, converted to active-high "on" flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      onReg  <= '0;
      clrReg <= 1'b0;
    end else begin
      onReg  <= {aHP, ~aLN, bHP, ~bLN, cHP, ~cLN};
      clrReg <= m3faultClr;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : gPhase
    motoro3_dead_chk #(.DEAD_MIN(DEAD_MIN)) uDeadChk (
      .clk      (clk),
      .rst      (rst),
      .hOn      (onReg[5 - 2*gi]),
      .lOn      (onReg[4 - 2*gi]),
      .deadViol (deadViol[gi]),
      .shootViol(shootViol[gi])
    );
  end

  assign newStep   = decodeStep(onReg);
  assign stepValid = (newStep != STEP_NONE);
  // lastStepReg survives a stall, so a still-held pattern does not re-lock.
  assign stepChg   = stepValid && (newStep != lastStepReg);
  // Zero or one device on is PWM chopping; anything else off-table is an error.
  assign badPat    = !stepValid && ($countones(onReg) > 1);
  assign delta     = stepDelta(newStep, lastStepReg);
  assign cntInc    = (&cntReg) ? cntReg : cntReg + 1'b1;
  assign stallHit  = (cntInc >= STALL_LIM);

  // Next-state logic for the lock/run FSM, period capture and stall detection.
  always_comb begin
    stateNext     = stateReg;
    stepNext      = stepReg;
    lastStepNext  = lastStepReg;
    dirRevNext    = dirRevReg;
    dirChgNext    = 1'b0;
    periodNext    = periodReg;
    periodVldNext = 1'b0;
    stalledNext   = stalledReg;
    seqEvt        = badPat;
    cntNext       = stepChg ? '0 : cntInc;
    case (stateReg)
      IDLE: begin
        if (stepChg) begin
          stateNext    = LOCK;
          stepNext     = newStep;
          lastStepNext = newStep;
          stalledNext  = 1'b0;
        end
      end
      LOCK: begin
        if (stepChg) begin
          stepNext     = newStep;
          lastStepNext = newStep;
          if (delta == 3'd1) begin
            stateNext  = RUN;
            dirRevNext = 1'b0;
          end else if (delta == 3'd5) begin
            stateNext  = RUN;
            dirRevNext = 1'b1;
          end else begin
            seqEvt = 1'b1;
          end
        end else if (stallHit) begin
          stateNext   = IDLE;
          stepNext    = STEP_NONE;
          stalledNext = 1'b1;
        end
      end
      RUN: begin
        if (stepChg) begin
          stepNext     = newStep;
          lastStepNext = newStep;
          if ((delta == 3'd1) || (delta == 3'd5)) begin
            periodNext    = cntInc;
            periodVldNext = 1'b1;
            if ((delta == 3'd5) != dirRevReg) begin
              dirRevNext = ~dirRevReg;
              dirChgNext = 1'b1;
            end
          end else begin
            seqEvt    = 1'b1;
            stateNext = LOCK;
          end
        end else if (stallHit) begin
          stateNext   = IDLE;
          stepNext    = STEP_NONE;
          stalledNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and status registers; sticky faults let a new fault beat a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      stepReg      <= STEP_NONE;
      lastStepReg  <= STEP_NONE;
      dirRevReg    <= 1'b0;
      dirChgReg    <= 1'b0;
      periodReg    <= '0;
      periodVldReg <= 1'b0;
      stalledReg   <= 1'b0;
      cntReg       <= '0;
      shootFltReg  <= 1'b0;
      deadFltReg   <= 1'b0;
      seqErrReg    <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      stepReg      <= stepNext;
      lastStepReg  <= lastStepNext;
      dirRevReg    <= dirRevNext;
      dirChgReg    <= dirChgNext;
      periodReg    <= periodNext;
      periodVldReg <= periodVldNext;
      stalledReg   <= stalledNext;
      cntReg       <= cntNext;
      shootFltReg  <= (|shootViol) | (shootFltReg & ~clrReg);
      deadFltReg   <= (|deadViol)  | (deadFltReg  & ~clrReg);
      seqErrReg    <= seqEvt       | (seqErrReg   & ~clrReg);
    end
  end

  assign m3step      = stepReg;
  assign m3running   = (stateReg == RUN);
  assign m3dirRev    = dirRevReg;
  assign m3dirChg    = dirChgReg;
  assign m3period    = periodReg;
  assign m3periodVld = periodVldReg;
  assign m3stalled   = stalledReg;
  assign m3shootFlt  = shootFltReg;
  assign m3deadFlt   = deadFltReg;
  assign m3seqErr    = seqErrReg;

endmodule

// File: tb/tb_motoro3_phase_mon.sv
// Directed bench for motoro3_phase_mon: six-step decode, direction, period,
// shoot-through, dead time, sequence errors, stall and mid-run reset.
module tb_motoro3_phase_mon;

  localparam int CNT_W     = 24;
  localparam int DEAD_MIN  = 10;
  localparam int STALL_CYC = 150;

  logic clk = 1'b0;
  logic rst, aHP, aLN, bHP, bLN, cHP, cLN, m3faultClr;
  logic [2:0]       m3step;
  logic             m3running, m3dirRev, m3dirChg, m3periodVld, m3stalled;
  logic [CNT_W-1:0] m3period;
  logic             m3shootFlt, m3deadFlt, m3seqErr;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  motoro3_phase_mon #(.CNT_W(CNT_W), .DEAD_MIN(DEAD_MIN), .STALL_CYC(STALL_CYC)) dut (
    .clk(clk), .rst(rst),
    .aHP(aHP), .aLN(aLN), .bHP(bHP), .bLN(bLN), .cHP(cHP), .cLN(cLN),
    .m3faultClr(m3faultClr),
    .m3step(m3step), .m3running(m3running), .m3dirRev(m3dirRev), .m3dirChg(m3dirChg),
    .m3period(m3period), .m3periodVld(m3periodVld), .m3stalled(m3stalled),
    .m3shootFlt(m3shootFlt), .m3deadFlt(m3deadFlt), .m3seqErr(m3seqErr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // on-vector {aH, aL, bH, bL, cH, cL}; low-side lines are active-low.
  task automatic drive(input logic [5:0] onVec);
    {aHP, aLN, bHP, bLN, cHP, cLN} = onVec ^ 6'b010101;
  endtask

  function automatic logic [5:0] stepOn(input int s);
    case (s)
      0: return 6'b100100;
      1: return 6'b100001;
      2: return 6'b001001;
      3: return 6'b011000;
      4: return 6'b010010;
      5: return 6'b000110;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic doReset();
    rst = 1'b1;
    m3faultClr = 1'b0;
    drive(6'b000000);
    tick(3);
    rst = 1'b0;
  endtask

  // Next step applied exactly 100 cycles after the previous one; 'gap' cycles
  // before it only the devices shared by both steps stay on.
  task automatic goStep(input int prevS, input int nextS, input int gap);
    tick(98 - gap);
    drive(stepOn(prevS) & stepOn(nextS));
    tick(gap);
    drive(stepOn(nextS));
    tick(2);
  endtask

  task automatic clrPulse();
    m3faultClr = 1'b1;
    tick(1);
    m3faultClr = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    doReset();
    chk("rst_step", 32'(m3step), 7);
    chk("rst_running", 32'(m3running), 0);
    chk("rst_period", 32'(m3period), 0);
    chk("rst_faults", 32'({m3shootFlt, m3deadFlt, m3seqErr, m3stalled}), 0);

    // Forward six-step, 100 cycles per step with 5-cycle gaps
    drive(stepOn(0));
    tick(2);
    chk("fwd_lock_step", 32'(m3step), 0);
    chk("fwd_lock_running", 32'(m3running), 0);
    goStep(0, 1, 5);
    chk("fwd_run", 32'(m3running), 1);
    chk("fwd_dir", 32'(m3dirRev), 0);
    chk("fwd_vld_first", 32'(m3periodVld), 0);
    for (int s = 2; s < 8; s++) begin
      goStep((s - 1) % 6, s % 6, 5);
      chk($sformatf("fwd_step%0d", s % 6), 32'(m3step), 32'(s % 6));
      chk("fwd_vld", 32'(m3periodVld), 1);
      chk("fwd_period", 32'(m3period), 100);
    end
    tick(1);
    chk("fwd_vld_pulse_end", 32'(m3periodVld), 0);
    chk("fwd_dir_end", 32'(m3dirRev), 0);
    chk("fwd_no_faults", 32'({m3shootFlt, m3deadFlt, m3seqErr}), 0);

    // Reverse 0,5,4,3 then forward 3->4
    doReset();
    drive(stepOn(0));
    tick(2);
    goStep(0, 5, 5);
    chk("rev_run", 32'(m3running), 1);
    chk("rev_dir", 32'(m3dirRev), 1);
    goStep(5, 4, 5);
    chk("rev_step4", 32'(m3step), 4);
    chk("rev_nochg", 32'(m3dirChg), 0);
    chk("rev_period", 32'(m3period), 100);
    goStep(4, 3, 5);
    chk("rev_step3", 32'(m3step), 3);
    goStep(3, 4, 5);
    chk("rev_dirchg", 32'(m3dirChg), 1);
    chk("rev_dir_fwd", 32'(m3dirRev), 0);
    chk("rev_seqerr", 32'(m3seqErr), 0);
    chk("rev_vld", 32'(m3periodVld), 1);
    tick(1);
    chk("rev_dirchg_end", 32'(m3dirChg), 0);

    // Illegal jump 1 -> 4 while running
    doReset();
    drive(stepOn(0));
    tick(2);
    goStep(0, 1, 5);
    chk("jmp_pre_run", 32'(m3running), 1);
    goStep(1, 4, 12);
    chk("jmp_seqerr", 32'(m3seqErr), 1);
    chk("jmp_lock", 32'(m3running), 0);
    chk("jmp_novld", 32'(m3periodVld), 0);
    chk("jmp_step", 32'(m3step), 4);
    chk("jmp_nodead", 32'(m3deadFlt), 0);

    // Shoot-through on phase A for one cycle
    doReset();
    drive(6'b110000);
    tick(1);
    drive(6'b000000);
    tick(1);
    chk("shoot_set", 32'(m3shootFlt), 1);
    chk("shoot_seqerr", 32'(m3seqErr), 1);
    chk("shoot_fsm", 32'({m3running, m3step}), 7);
    tick(10);
    chk("shoot_sticky", 32'(m3shootFlt), 1);
    clrPulse();
    chk("shoot_clr", 32'(m3shootFlt), 0);
    tick(15);
    drive(6'b110000);
    m3faultClr = 1'b1;
    tick(1);
    drive(6'b000000);
    m3faultClr = 1'b0;
    tick(1);
    chk("shoot_wins_clr", 32'(m3shootFlt), 1);
    clrPulse();
    chk("shoot_clr2", 32'({m3shootFlt, m3seqErr}), 0);

    // Dead time on phase B: 4-cycle gap, 10-cycle gap, 9-cycle gap
    doReset();
    drive(6'b001000);
    tick(3);
    drive(6'b000000);
    tick(4);
    drive(6'b000100);
    tick(2);
    chk("dead_gap4", 32'(m3deadFlt), 1);
    chk("dead_gap4_seq", 32'(m3seqErr), 0);
    clrPulse();
    chk("dead_clr", 32'(m3deadFlt), 0);
    drive(6'b000000);
    tick(10);
    drive(6'b001000);
    tick(2);
    chk("dead_gap10", 32'(m3deadFlt), 0);
    drive(6'b000000);
    tick(9);
    drive(6'b000100);
    tick(2);
    chk("dead_gap9", 32'(m3deadFlt), 1);

    // Stall after STALL_CYC cycles without a step change
    doReset();
    drive(stepOn(2));
    tick(2);
    chk("stall_lock", 32'(m3step), 2);
    tick(149);
    chk("stall_early", 32'(m3stalled), 0);
    tick(1);
    chk("stall_set", 32'(m3stalled), 1);
    chk("stall_step", 32'(m3step), 7);
    chk("stall_idle", 32'(m3running), 0);
    tick(3);
    chk("stall_hold_norelock", 32'(m3step), 7);
    drive(stepOn(3));
    tick(2);
    chk("stall_clear", 32'(m3stalled), 0);
    chk("stall_relock", 32'(m3step), 3);

    // Reset asserted mid-run
    doReset();
    drive(stepOn(0));
    tick(2);
    goStep(0, 1, 5);
    goStep(1, 2, 5);
    chk("mrst_pre_period", 32'(m3period), 100);
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("mrst_step", 32'(m3step), 7);
    chk("mrst_flags", 32'({m3running, m3dirRev, m3dirChg, m3periodVld, m3stalled,
                           m3shootFlt, m3deadFlt, m3seqErr}), 0);
    chk("mrst_period", 32'(m3period), 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
